// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch/writeback/ID-EX signal bundle for the decode stage
interface id_stage_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int RW = $clog2(NREG);

  // fetch side
  logic [XLEN-1:0] pc_ID;
  logic [31:0]     inst_ID;
  logic [2:0]      reg_mux_sel;
  // redirect controls from EX / CSR unit
  logic            pc_sel;
  logic            epc_taken;
  // writeback port into the register file
  logic            wb_en;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  // ID/EX pipeline register
  logic [XLEN-1:0] pc_EX;
  logic [XLEN-1:0] rs1_data_EX;
  logic [XLEN-1:0] rs2_data_EX;
  logic [XLEN-1:0] imm_EX;
  logic [RW-1:0]   rs1_EX;
  logic [RW-1:0]   rs2_EX;
  logic [RW-1:0]   rd_EX;
  logic [3:0]      alu_op_EX;
  logic [2:0]      funct3_EX;
  logic            reg_wr_EX;
  logic            mem_rd_EX;
  logic            mem_wr_EX;
  logic            br_en_EX;
  logic            jump_EX;
  logic            sel_A_EX;
  logic            sel_B_EX;
  logic            csr_rd_EX;
  logic            csr_wr_EX;
  logic            illegal_EX;
  logic [1:0]      wb_sel_EX;

  // surrounding pipeline: drives decode inputs, observes ID/EX outputs
  modport master (
    output pc_ID, inst_ID, pc_sel, epc_taken, wb_en, wb_rd, wb_data,
    input  reg_mux_sel, pc_EX, rs1_data_EX, rs2_data_EX, imm_EX,
           rs1_EX, rs2_EX, rd_EX, alu_op_EX, funct3_EX,
           reg_wr_EX, mem_rd_EX, mem_wr_EX, br_en_EX, jump_EX,
           sel_A_EX, sel_B_EX, csr_rd_EX, csr_wr_EX, illegal_EX, wb_sel_EX
  );

  // decode stage itself
  modport slave (
    input  pc_ID, inst_ID, pc_sel, epc_taken, wb_en, wb_rd, wb_data,
    output reg_mux_sel, pc_EX, rs1_data_EX, rs2_data_EX, imm_EX,
           rs1_EX, rs2_EX, rd_EX, alu_op_EX, funct3_EX,
           reg_wr_EX, mem_rd_EX, mem_wr_EX, br_en_EX, jump_EX,
           sel_A_EX, sel_B_EX, csr_rd_EX, csr_wr_EX, illegal_EX, wb_sel_EX
  );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I+Zicsr decode, register file, load-use hazard, ID/EX register
module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         reset,
  id_stage_if.slave    bus
);
  localparam int RW = $clog2(NREG);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] MUX_NORMAL = 3'b001;
  localparam logic [2:0] MUX_FLUSH  = 3'b010;
  localparam logic [2:0] MUX_STALL  = 3'b100;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [3:0]      alu_op;
    logic [2:0]      funct3;
    logic            reg_wr;
    logic            mem_rd;
    logic            mem_wr;
    logic            br_en;
    logic            jump;
    logic            sel_a;
    logic            sel_b;
    logic            csr_rd;
    logic            csr_wr;
    logic            illegal;
    logic [1:0]      wb_sel;
  } ex_t;

  logic [XLEN-1:0] r_regs [NREG];
  ex_t             r_ex;
  ex_t             w_dec;

  logic [31:0]     w_inst;
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [RW-1:0]   w_rd;
  logic [RW-1:0]   w_rs1;
  logic [RW-1:0]   w_rs2;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_wr_rd;
  logic            w_known;
  logic            w_flush;
  logic            w_hazard;

  assign w_inst = bus.inst_ID;
  assign w_opc  = w_inst[6:0];
  assign w_f3   = w_inst[14:12];
  assign w_rd   = w_inst[11:7];
  assign w_rs1  = w_inst[19:15];
  assign w_rs2  = w_inst[24:20];

  assign w_imm_i = {{(XLEN-12){w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{(XLEN-12){w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{(XLEN-13){w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                    w_inst[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){w_inst[31]}}, w_inst[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-21){w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                    w_inst[30:21], 1'b0};

  // Register file reads: x0 is zero, a same-cycle writeback bypasses the array
  always_comb begin
    w_rs1_val = r_regs[w_rs1];
    w_rs2_val = r_regs[w_rs2];
    if (bus.wb_en && bus.wb_rd == w_rs1) w_rs1_val = bus.wb_data;
    if (bus.wb_en && bus.wb_rd == w_rs2) w_rs2_val = bus.wb_data;
    if (w_rs1 == '0) w_rs1_val = '0;
    if (w_rs2 == '0) w_rs2_val = '0;
  end

  // Register file write port; x0 is never written so it stays at its reset zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != '0) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Instruction decode into the next ID/EX contents
  always_comb begin
    w_dec        = '0;
    w_use_rs1    = 1'b0;
    w_use_rs2    = 1'b0;
    w_wr_rd      = 1'b0;
    w_known      = 1'b1;
    w_dec.pc     = bus.pc_ID;
    w_dec.funct3 = w_f3;
    case (w_opc)
      OPC_R: begin
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
        w_wr_rd      = 1'b1;
        w_dec.alu_op = {w_inst[30], w_f3};
      end
      OPC_IALU: begin
        w_use_rs1    = 1'b1;
        w_wr_rd      = 1'b1;
        w_dec.sel_b  = 1'b1;
        w_dec.imm    = w_imm_i;
        // only shifts carry the arithmetic bit; elsewhere inst[30] is immediate data
        w_dec.alu_op = {(w_f3 == 3'b101) & w_inst[30], w_f3};
      end
      OPC_LOAD: begin
        w_use_rs1    = 1'b1;
        w_wr_rd      = 1'b1;
        w_dec.mem_rd = 1'b1;
        w_dec.sel_b  = 1'b1;
        w_dec.imm    = w_imm_i;
        w_dec.wb_sel = 2'b01;
      end
      OPC_STORE: begin
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
        w_dec.mem_wr = 1'b1;
        w_dec.sel_b  = 1'b1;
        w_dec.imm    = w_imm_s;
      end
      OPC_BRANCH: begin
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
        w_dec.br_en  = 1'b1;
        w_dec.sel_a  = 1'b1;
        w_dec.sel_b  = 1'b1;
        w_dec.imm    = w_imm_b;
      end
      OPC_LUI: begin
        // rs1 stays index 0 so operand A reads zero and the ALU passes the immediate
        w_wr_rd      = 1'b1;
        w_dec.sel_b  = 1'b1;
        w_dec.imm    = w_imm_u;
      end
      OPC_AUIPC: begin
        w_wr_rd      = 1'b1;
        w_dec.sel_a  = 1'b1;
        w_dec.sel_b  = 1'b1;
        w_dec.imm    = w_imm_u;
      end
      OPC_JAL: begin
        w_wr_rd      = 1'b1;
        w_dec.jump   = 1'b1;
        w_dec.sel_a  = 1'b1;
        w_dec.sel_b  = 1'b1;
        w_dec.imm    = w_imm_j;
        w_dec.wb_sel = 2'b10;
      end
      OPC_JALR: begin
        w_use_rs1    = 1'b1;
        w_wr_rd      = 1'b1;
        w_dec.jump   = 1'b1;
        w_dec.sel_b  = 1'b1;
        w_dec.imm    = w_imm_i;
        w_dec.wb_sel = 2'b10;
      end
      OPC_SYSTEM: begin
        w_dec.sel_b = 1'b1;
        w_dec.imm   = w_imm_i;
        if (w_f3 != 3'b000) begin
          w_wr_rd      = 1'b1;
          w_use_rs1    = ~w_f3[2];
          w_dec.rs1    = w_rs1;  // carries zimm for the immediate CSR forms
          w_dec.csr_rd = 1'b1;
          // csrrs/csrrc with rs1 field zero are pure reads
          w_dec.csr_wr = ~(w_f3[1] && w_rs1 == '0);
          w_dec.wb_sel = 2'b11;
        end
      end
      default: w_known = 1'b0;
    endcase
    if (w_use_rs1) begin
      w_dec.rs1      = w_rs1;
      w_dec.rs1_data = w_rs1_val;
    end
    if (w_use_rs2) begin
      w_dec.rs2      = w_rs2;
      w_dec.rs2_data = w_rs2_val;
    end
    if (w_wr_rd) begin
      w_dec.rd     = w_rd;
      w_dec.reg_wr = 1'b1;
    end
    if (!w_known) begin
      // all-zero word is the fetch-flush bubble, not an illegal instruction
      w_dec         = '0;
      w_dec.pc      = bus.pc_ID;
      w_dec.illegal = (w_inst != 32'h0);
    end
  end

  assign w_flush  = bus.pc_sel | bus.epc_taken;
  assign w_hazard = r_ex.mem_rd && (r_ex.rd != '0) &&
                    ((w_use_rs1 && w_rs1 == r_ex.rd) || (w_use_rs2 && w_rs2 == r_ex.rd));

  // Fetch control: flush outranks stall, reset forces flush
  always_comb begin
    bus.reg_mux_sel = MUX_NORMAL;
    if (!reset)        bus.reg_mux_sel = MUX_FLUSH;
    else if (w_flush)  bus.reg_mux_sel = MUX_FLUSH;
    else if (w_hazard) bus.reg_mux_sel = MUX_STALL;
  end

  // ID/EX pipeline register: bubble on flush or load-use stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_ex <= '0;
    else if (w_flush || w_hazard) r_ex <= '0;
    else                          r_ex <= w_dec;
  end

  assign bus.pc_EX       = r_ex.pc;
  assign bus.rs1_data_EX = r_ex.rs1_data;
  assign bus.rs2_data_EX = r_ex.rs2_data;
  assign bus.imm_EX      = r_ex.imm;
  assign bus.rs1_EX      = r_ex.rs1;
  assign bus.rs2_EX      = r_ex.rs2;
  assign bus.rd_EX       = r_ex.rd;
  assign bus.alu_op_EX   = r_ex.alu_op;
  assign bus.funct3_EX   = r_ex.funct3;
  assign bus.reg_wr_EX   = r_ex.reg_wr;
  assign bus.mem_rd_EX   = r_ex.mem_rd;
  assign bus.mem_wr_EX   = r_ex.mem_wr;
  assign bus.br_en_EX    = r_ex.br_en;
  assign bus.jump_EX     = r_ex.jump;
  assign bus.sel_A_EX    = r_ex.sel_a;
  assign bus.sel_B_EX    = r_ex.sel_b;
  assign bus.csr_rd_EX   = r_ex.csr_rd;
  assign bus.csr_wr_EX   = r_ex.csr_wr;
  assign bus.illegal_EX  = r_ex.illegal;
  assign bus.wb_sel_EX   = r_ex.wb_sel;
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed-vector self-checking bench for id_stage
module tb_id_stage;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  id_stage_if #(.XLEN(32), .NREG(32)) bus ();

  id_stage #(.XLEN(32), .NREG(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {reg_wr, mem_rd, mem_wr, br_en, jump, sel_A, sel_B, csr_rd, csr_wr, illegal, wb_sel}
  wire [11:0] ctl = {bus.reg_wr_EX, bus.mem_rd_EX, bus.mem_wr_EX, bus.br_en_EX,
                     bus.jump_EX, bus.sel_A_EX, bus.sel_B_EX, bus.csr_rd_EX,
                     bus.csr_wr_EX, bus.illegal_EX, bus.wb_sel_EX};

  localparam logic [31:0] ADD_X6_X5_X0 = 32'h0002_8333;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h0000_0333;
  localparam logic [31:0] ADDI_X1_M1   = 32'hFFF0_0093;
  localparam logic [31:0] BEQ_M8       = 32'hFE00_0CE3;
  localparam logic [31:0] LW_X2_X1     = 32'h0000_A103;
  localparam logic [31:0] ADD_X3_X2_X2 = 32'h0021_01B3;
  localparam logic [31:0] ADD_X3_X4_X4 = 32'h0042_01B3;
  localparam logic [31:0] OPC_7F       = 32'h0000_007F;
  localparam logic [31:0] CSRRS_MST    = 32'h3000_20F3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset         = 1'b0;
    bus.pc_ID     = '0;
    bus.inst_ID   = '0;
    bus.pc_sel    = 1'b0;
    bus.epc_taken = 1'b0;
    bus.wb_en     = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;

    // reset held low
    repeat (2) step();
    check("rst_mux", {29'b0, bus.reg_mux_sel}, 32'h2);
    check("rst_ctl", {20'b0, ctl}, 32'h0);
    check("rst_pc", bus.pc_EX, 32'h0);
    reset = 1'b1;
    #1;
    check("rel_mux", {29'b0, bus.reg_mux_sel}, 32'h1);

    // x5 reads zero after reset
    bus.pc_ID = 32'h100; bus.inst_ID = ADD_X6_X5_X0;
    step();
    check("x5_zero", bus.rs1_data_EX, 32'h0);
    check("add_pc", bus.pc_EX, 32'h100);

    // writeback x5 while add reads it: bypass
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    step();
    bus.wb_en = 1'b0;
    check("byp_rs1", bus.rs1_data_EX, 32'hDEADBEEF);
    check("byp_rd", {27'b0, bus.rd_EX}, 32'd6);
    check("byp_alu", {28'b0, bus.alu_op_EX}, 32'h0);
    check("byp_regwr", {31'b0, bus.reg_wr_EX}, 32'h1);
    // value now held in the array
    step();
    check("rf_x5", bus.rs1_data_EX, 32'hDEADBEEF);

    // immediates
    bus.inst_ID = ADDI_X1_M1;
    step();
    check("addi_imm", bus.imm_EX, 32'hFFFFFFFF);
    check("addi_ctl", {20'b0, ctl}, {20'b0, 12'b1000_0010_0000});
    bus.inst_ID = BEQ_M8;
    step();
    check("beq_imm", bus.imm_EX, 32'hFFFFFFF8);
    check("beq_ctl", {20'b0, ctl}, {20'b0, 12'b0001_0110_0000});

    // load-use stall
    bus.inst_ID = LW_X2_X1;
    step();
    check("lw_ctl", {20'b0, ctl}, {20'b0, 12'b1100_0010_0001});
    bus.inst_ID = ADD_X3_X2_X2;
    #1;
    check("lu_mux_stall", {29'b0, bus.reg_mux_sel}, 32'h4);
    step();
    check("lu_bubble", {20'b0, ctl}, 32'h0);
    check("lu_bubble_rd", {27'b0, bus.rd_EX}, 32'h0);
    check("lu_mux_resume", {29'b0, bus.reg_mux_sel}, 32'h1);
    step();
    check("lu_issue_rd", {27'b0, bus.rd_EX}, 32'd3);
    check("lu_issue_rs2", {27'b0, bus.rs2_EX}, 32'd2);

    // load followed by independent add
    bus.inst_ID = LW_X2_X1;
    step();
    bus.inst_ID = ADD_X3_X4_X4;
    #1;
    check("nolu_mux", {29'b0, bus.reg_mux_sel}, 32'h1);
    step();
    check("nolu_rd", {27'b0, bus.rd_EX}, 32'd3);

    // flush during hazard wins
    bus.inst_ID = LW_X2_X1;
    step();
    bus.inst_ID = ADD_X3_X2_X2; bus.pc_sel = 1'b1;
    #1;
    check("fl_mux", {29'b0, bus.reg_mux_sel}, 32'h2);
    step();
    bus.pc_sel = 1'b0;
    check("fl_bubble", {20'b0, ctl}, 32'h0);
    check("fl_pc", bus.pc_EX, 32'h0);
    bus.epc_taken = 1'b1;
    #1;
    check("epc_mux", {29'b0, bus.reg_mux_sel}, 32'h2);
    bus.epc_taken = 1'b0;

    // write to x0 ignored
    bus.inst_ID = ADD_X6_X0_X0;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h12345678;
    step();
    bus.wb_en = 1'b0;
    check("x0_byp", bus.rs1_data_EX, 32'h0);
    step();
    check("x0_rf", bus.rs1_data_EX, 32'h0);

    // decode errors and CSR
    bus.inst_ID = OPC_7F;
    step();
    check("illegal_ctl", {20'b0, ctl}, {20'b0, 12'b0000_0000_0100});
    bus.inst_ID = 32'h0;
    step();
    check("bubble_ctl", {20'b0, ctl}, 32'h0);
    bus.inst_ID = CSRRS_MST;
    step();
    check("csrrs_ctl", {20'b0, ctl}, {20'b0, 12'b1000_0011_0011});
    check("csrrs_rd", {27'b0, bus.rd_EX}, 32'd1);

    // asynchronous reset mid-operation
    bus.inst_ID = ADDI_X1_M1;
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_ctl", {20'b0, ctl}, 32'h0);
    check("mid_rst_imm", bus.imm_EX, 32'h0);
    check("mid_rst_mux", {29'b0, bus.reg_mux_sel}, 32'h2);
    step();
    reset = 1'b1;
    #1;
    check("post_rst_hold", bus.imm_EX, 32'h0);
    step();
    check("post_rst_imm", bus.imm_EX, 32'hFFFFFFFF);
    bus.inst_ID = ADD_X6_X5_X0;
    step();
    check("post_rst_x5", bus.rs1_data_EX, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage pipeline, directly downstream of the fetch stage. It consumes the fetch stage's `pc_ID`/`inst_ID` pipeline register and decodes RV32I plus Zicsr. It holds the 32×32 integer register file, written by writeback, and generates sign-extended immediates. It detects load-use hazards and drives the 3-bit `reg_mux_sel` (normal/flush/stall) back to fetch, then registers everything into the ID/EX pipeline register.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `NREG`, 32, architectural registers (x0 hard-wired zero)

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  one clock; reset is asynchronous and active-low
- `pc_ID`  in  32  PC of instruction in ID
- `inst_ID`  in  32  instruction in ID (0 = bubble from fetch flush)
- `pc_sel`  in  1  branch/jump taken in EX (redirect)
- `epc_taken`  in  1  CSR trap/return redirect
- `wb_en`  in  1  writeback enable
- `wb_rd`  in  5  writeback destination
- `wb_data`  in  32  writeback value
- `reg_mux_sel`  out  3  to fetch: 3'b001 normal, 3'b010 flush, 3'b100 stall
- `pc_EX`, `rs1_data_EX`, `rs2_data_EX`, `imm_EX`  out  32 each  ID/EX datapath
- `rs1_EX`, `rs2_EX`, `rd_EX`  out  5 each  register indices
- `alu_op_EX`  out  4  {funct7[5], funct3} ALU code
- `funct3_EX`  out  3  load/store size, branch type, CSR op
- `reg_wr_EX`, `mem_rd_EX`, `mem_wr_EX`, `br_en_EX`, `jump_EX`, `sel_A_EX`, `sel_B_EX`, `csr_rd_EX`, `csr_wr_EX`, `illegal_EX`  out  1 each  control
- `wb_sel_EX`  out  2  00 ALU, 01 memory, 10 PC+4, 11 CSR

## Operation
- Opcode classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, SYSTEM 1110011.
- Immediates (sign-extended from bit 31): I, S, B (bit0=0), U (low 12 = 0), J (bit0=0). R-type imm = 0.
- `alu_op`: R → {inst[30], funct3}. I-ALU → {inst[30] only if funct3=101, funct3}. LUI/AUIPC/LOAD/STORE/BRANCH/JAL/JALR → 4'b0000 (add).
- `sel_A`=1 selects PC (AUIPC, JAL, BRANCH). `sel_B`=1 selects imm (all except R). LUI: rs1 index forced 0.
- SYSTEM with funct3≠000: csr_rd=1, wb_sel=11, reg_wr=1; csr_wr=1 unless (funct3[1]=1 and rs1 field=0).
- Unknown opcode: bubble controls plus `illegal_EX`=1. `inst_ID`=0 decodes as bubble with illegal=0.
- Register file: reads combinational, x0 reads 0. Write on posedge when `wb_en` and `wb_rd`≠0. Same-cycle write-through: rs match wb_rd≠0 with wb_en → read returns `wb_data`.
- rs1 used by R, I-ALU, LOAD, STORE, BRANCH, JALR, CSR with funct3[2]=0. rs2 used by R, STORE, BRANCH.
- Load-use hazard: `mem_rd_EX` & `rd_EX`≠0 & `rd_EX` equals a used rs.
- `reg_mux_sel` (combinational), priority: reset low → 010; `pc_sel`|`epc_taken` → 010; hazard → 100; else 001.
- ID/EX register: on flush or hazard, load bubble (all control 0, rd/rs 0, data 0); else load decoded fields.
- Async reset clears the register file and all ID/EX outputs to 0.

## Timing
- Decode-to-EX latency: 1 cycle. The ID/EX register updates every posedge, with no enable.
- Load-use stall lasts exactly 1 cycle. The inserted bubble clears `mem_rd_EX`, so the next cycle returns 001.
- Flush and stall in the same cycle: flush wins, giving 010 and a bubble.
- A writeback in the same cycle as the ID read is visible via the bypass. No extra stall.
- Reset deasserted mid-operation: the ID/EX register stays at 0 until the first posedge after release. `reg_mux_sel` = 010 while low.

## Test plan
- Reset: hold `reset`=0, then release → all `*_EX`=0, `reg_mux_sel`=010 while low, 001 after. Reading x5 gives 0.
- Write x5=0xDEADBEEF via wb while ID holds `add x6,x5,x0` (0x00028333) → next cycle `rs1_data_EX`=0xDEADBEEF, `rd_EX`=6, `alu_op_EX`=0000, `reg_wr_EX`=1.
- Immediates: `addi x1,x0,-1` (0xFFF00093) → `imm_EX`=0xFFFFFFFF. `beq` with offset −8 (0xFE000CE3) → `imm_EX`=0xFFFFFFF8, `br_en_EX`=1, `sel_A_EX`=1.
- Load-use: `lw x2,0(x1)` followed by `add x3,x2,x2` → one cycle `reg_mux_sel`=100 with a bubble in EX, then `add` is issued with 001. The same load followed by `add x3,x4,x4` → no stall.
- Flush: `pc_sel`=1 during the hazard cycle → `reg_mux_sel`=010 and a bubble. `wb_en` with `wb_rd`=0 leaves x0 reading 0.
- Decode errors: opcode 0x7F → `illegal_EX`=1 and all other control 0. `csrrs x1,mstatus,x0` → `csr_rd_EX`=1, `csr_wr_EX`=0, `wb_sel_EX`=11.
